addsub_seq_ctrl: RTL
====================

Name: addsub_seq_ctrl

Overview:
- Multi-cycle sequencer that runs NIBBLES*4-bit add/subtract on one 4-bit add/sub slice, one nibble per clock, least significant nibble first.
- The carry is registered between nibbles.
- Sits between a requester and the result consumer, with valid/ready handshakes on both sides.
- Uses the same slice semantics as the team's 4-bit adder/subtractor: B is XORed with sub, and the carry-in of nibble 0 equals sub. The slice is internal because later nibbles need an external carry-in.

Parameters:
- NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES). Legal range 1..16.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  requester presents an operation
- in_ready  output  1  block can accept; high only in IDLE
- a  input  W  operand A, sampled on acceptance
- b  input  W  operand B, sampled on acceptance
- sub  input  1  0 = A+B, 1 = A-B; sampled on acceptance
- out_valid  output  1  result, cout and overflow valid
- out_ready  input  1  consumer takes the result
- result  output  W  sum or difference, modulo 2^W
- cout  output  1  final carry out (for subtract, 1 = no borrow, i.e. A >= B unsigned)
- overflow  output  1  signed two's-complement overflow

Behaviour:
- States: IDLE, RUN, DONE; 2-bit state register. Nibble index register is ceil(log2(NIBBLES))+1 bits wide.
- Reset (async): state=IDLE, idx=0, carry=0, result=0, cout=0, overflow=0, out_valid=0. in_ready=1 while in IDLE, but no acceptance occurs while rst is high.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from registered state only, with no combinational path from inputs.
- IDLE: on a clock edge with in_valid=1, latch a, b and sub into operand registers, set carry=sub, clear result, set idx=0, go to RUN. Otherwise stay.
- RUN, each edge:
  - t = A[idx] + (B[idx] XOR {4{sub}}) + carry.
  - result[idx] = t[3:0]; carry = t[4]; idx++.
  - When idx was NIBBLES-1: cout=t[4], overflow = (A_msb == B'_msb) && (t[3] != A_msb), go to DONE.
  - A_msb is A[W-1]; B'_msb is B[W-1]^sub.
- Latency: out_valid rises exactly NIBBLES cycles after the acceptance edge. Throughput is one operation per NIBBLES+2 cycles when out_ready is held high.
- DONE: hold result, cout and overflow stable while out_ready=0 (indefinite backpressure). On an edge with out_ready=1, go to IDLE. result, cout and overflow keep their values until the next acceptance clears result.
- Input changes on a, b or sub after acceptance have no effect on the operation in flight.
- in_valid during RUN or DONE is ignored and not queued; the requester must hold it until in_ready.
- rst mid-RUN or mid-DONE: immediate abort to reset values. No partial result is ever signalled valid.
- NIBBLES=1: RUN lasts one cycle; matches a single 4-bit add/sub.
- Arithmetic is modulo 2^W. Subtract 0-0 gives result 0, cout 1.

Optional Feature:
- Macro ADDSUB_SEQ_ZERO_FLAG_EN.
- When defined: extra output port zero (1 bit), registered. Reset value 0. Cleared on acceptance. In DONE it equals (result == 0), computed incrementally by ANDing each nibble's zero test during RUN. Held stable in DONE like result.
- When undefined: no zero port and no associated logic. All other behaviour is identical.

Test Plan:
- NIBBLES=4, a=0x1234, b=0x0FFF, sub=0 -> out_valid 4 cycles after acceptance; result=0x2233, cout=0, overflow=0.
- a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, cout=0, overflow=0. Then a=0x0007, b=0x0005, sub=1 -> result=0x0002, cout=1.
- a=0x7FFF, b=0x0001, sub=0 -> result=0x8000, overflow=1, cout=0. Then a=0x8000, b=0x0001, sub=1 -> result=0x7FFF, overflow=1, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE and toggle a, b and in_valid -> result, cout, overflow and out_valid stay stable and in_ready stays 0. Raise out_ready -> IDLE next cycle, and in_ready=1.
- Assert rst for 1 cycle at the 2nd RUN cycle of a=0xFFFF+b=0x0001 -> all outputs at reset values immediately. A following operation 0x0001+0x0001 gives 0x0002 with no residual carry.
- With ADDSUB_SEQ_ZERO_FLAG_EN, a=0x1234, b=0x1234, sub=1 -> result=0x0000, zero=1, cout=1. Then 0x0001-0x0000 -> zero=0.

Source files
------------

// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial add/subtract sequencer: one 4-bit slice, carry registered.
// Optional zero flag output enabled by defining ADDSUB_SEQ_ZERO_FLAG_EN.
module addsub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  output logic                 zero,
`endif
  output logic                 overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          nstate;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic            carry;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      b_x;
  logic [4:0]      t;
  logic            last;
  logic            accept;
`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  logic            zacc;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && in_valid;
  assign last      = (idx == IW'(NIBBLES - 1));

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[i*4 +: 4];
        b_nib = b_q[i*4 +: 4];
      end
    end
  end

  // The 4-bit add/sub slice with external carry-in.
  always_comb begin
    b_x = b_nib ^ {4{sub_q}};
    t   = {1'b0, a_nib} + {1'b0, b_x} + {4'b0, carry};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state decode.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (in_valid)  nstate = RUN;
      RUN:     if (last)      nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Operand capture, per-nibble accumulation and final flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      idx      <= '0;
      a_q      <= a;
      b_q      <= b;
      sub_q    <= sub;
      carry    <= sub;
      result   <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == IW'(i)) result[i*4 +: 4] <= t[3:0];
      end
      carry <= t[4];
      idx   <= idx + IW'(1);
      if (last) begin
        cout     <= t[4];
        overflow <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) &&
                    (t[3] != a_q[W-1]);
      end
    end
  end

`ifdef ADDSUB_SEQ_ZERO_FLAG_EN
  // Zero flag: running AND of per-nibble zero tests, published on the last nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zacc <= 1'b0;
      zero <= 1'b0;
    end else if (accept) begin
      zacc <= 1'b1;
      zero <= 1'b0;
    end else if (state == RUN) begin
      zacc <= zacc & (t[3:0] == 4'd0);
      if (last) zero <= zacc & (t[3:0] == 4'd0);
    end
  end
`endif

endmodule
